// File: rtl/dflipflop.sv
// Parameterised D register with capture enable, asynchronous active-low reset
// and a complementary output derived directly from the stored value.
`timescale 1ns/1ps

module dflipflop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  // Reset wins over enable; en only decides between capture and hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

  // No separate state for qn, so it can never disagree with q, even in reset.
  assign qn = ~q;

endmodule

// File: tb/tb_dflipflop.sv
// Bench for dflipflop: a 1-bit default instance and an 8-bit instance with reset value A5,
// driven by directed timing steps plus randomized enable/data/reset-pulse traffic.
`timescale 1ns/1ps

module tb_dflipflop;

  logic       clk = 1'b0;
  logic       reset1 = 1'b1;
  logic       en1 = 1'b0;
  logic [0:0] d1 = 1'b0;
  logic [0:0] q1, qn1;
  logic       reset8 = 1'b1;
  logic       en8 = 1'b0;
  logic [7:0] d8 = 8'h00;
  logic [7:0] q8, qn8;

  int checks = 0;
  int errors = 0;

  // Reference state: what each register should hold, from the capture/hold/reset rules.
  logic [0:0] exp1;
  logic [7:0] exp8;
  bit         pulse1, pulse8;

  localparam logic [7:0] RV8 = 8'hA5;

  always #5 clk = ~clk;

  dflipflop u_dut1 (
    .clk   (clk),
    .reset (reset1),
    .d     (d1),
    .en    (en1),
    .q     (q1),
    .qn    (qn1)
  );

  dflipflop #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk   (clk),
    .reset (reset8),
    .d     (d8),
    .en    (en8),
    .q     (q8),
    .qn    (qn8)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Asynchronous reset assertion with no clock edge in between.
    #1   reset1 = 1'b0; reset8 = 1'b0;
    #0.5 checkOutput("rst_q1", q1, 1'b0);
         checkOutput("rst_qn1", qn1, 1'b1);
         checkOutput("rst_q8", q8, 8'hA5);
         checkOutput("rst_qn8", qn8, 8'h5A);
    #0.5 reset1 = 1'b1; reset8 = 1'b1;
    #1   en1 = 1'b1; d1 = 1'b1; en8 = 1'b1; d8 = 8'h3C;
    #1   checkOutput("released_q1_before_edge", q1, 1'b0);
         checkOutput("released_q8_before_edge", q8, 8'hA5);
    #2   checkOutput("first_capture_q1", q1, 1'b1);
         checkOutput("first_capture_qn1", qn1, 1'b0);
         checkOutput("first_capture_q8", q8, 8'h3C);
         checkOutput("first_capture_qn8", qn8, 8'hC3);

    // Data tracking: d changes between edges only show up at the following edge.
    #6   d1 = 1'b0;
    #4   checkOutput("track_15", q1, 1'b0);
    #2   d1 = 1'b1;
    #4   checkOutput("track_between", q1, 1'b0);
    #4   checkOutput("track_25", q1, 1'b1);
    #2   d1 = 1'b0;
    #8   checkOutput("track_35", q1, 1'b0);
         checkOutput("track_q8_held", q8, 8'h3C);

    // Randomized traffic; time is now 1 ns after a rising edge.
    exp1 = 1'b0;
    exp8 = 8'h3C;
    for (int i = 0; i < 150; i++) begin
      #2;
      pulse1 = ($urandom_range(7) == 0);
      pulse8 = ($urandom_range(7) == 0);
      if (pulse1) begin reset1 = 1'b0; exp1 = 1'b0; end
      if (pulse8) begin reset8 = 1'b0; exp8 = RV8; end
      #1;
      checkOutput("rand_mid_q1", q1, exp1);
      checkOutput("rand_mid_q8", q8, exp8);
      #1;
      reset1 = 1'b1;
      reset8 = 1'b1;
      en1 = 1'($urandom_range(1));
      d1  = 1'($urandom_range(1));
      en8 = 1'($urandom_range(1));
      d8  = 8'($urandom_range(255));
      @(posedge clk);
      if (en1) exp1 = d1;
      if (en8) exp8 = d8;
      #1;
      checkOutput("rand_q1", q1, exp1);
      checkOutput("rand_qn1", qn1, {~exp1});
      checkOutput("rand_q8", q8, exp8);
      checkOutput("rand_qn8", qn8, {~exp8});
    end

    // Hold with enable low while d toggles across five edges.
    #2 en1 = 1'b1; d1 = 1'b1;
    @(posedge clk); #1 checkOutput("hold_load", q1, 1'b1);
    en1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2 d1 = ~d1;
      @(posedge clk); #1;
      checkOutput("hold_q1", q1, 1'b1);
      checkOutput("hold_qn1", qn1, 1'b0);
    end

    // Reset pulse between edges overrides hold; q stays reset after release with en low.
    #1 reset1 = 1'b0;
    #1 checkOutput("pulse_q1", q1, 1'b0);
       checkOutput("pulse_qn1", qn1, 1'b1);
    #4 reset1 = 1'b1;
    @(posedge clk); #1 checkOutput("pulse_release_hold1", q1, 1'b0);
    @(posedge clk); #1 checkOutput("pulse_release_hold2", q1, 1'b0);

    // Mid-cycle reset with d=1, en=1 held across edges.
    #2 en1 = 1'b1; d1 = 1'b1;
    @(posedge clk); #1 checkOutput("midrst_load", q1, 1'b1);
    #2   reset1 = 1'b0;
    #0.5 checkOutput("midrst_async", q1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 checkOutput("midrst_held", q1, 1'b0);
    end
    #3 reset1 = 1'b1;
    @(posedge clk); #1 checkOutput("midrst_recapture", q1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
